// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetcher with PC sequencing, fault/halt states and a retire counter.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [63:0] pc,
    input  logic        commit,
    input  logic [1:0]  npc_sel,
    input  logic [63:0] branch_target,
    input  logic [63:0] jalr_target,
    input  logic        halt,
    output logic        fetch_fault,
    output logic        halted,
    output logic [63:0] retire_cnt
);
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT, S_HALTED} state_t;
    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d, retire_q, retire_d, npc;
    logic [31:0] instr_q, instr_d;
    always_comb begin
        npc      = npc_sel == 2'd1 ? branch_target
                 : npc_sel == 2'd2 ? {jalr_target[63:1], 1'b0}
                 : pc_q + 64'd4;
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_d = retire_q;
        case (state_q)
            S_REQ:  if (imem_req_ready) state_d = S_WAIT;
            S_WAIT: if (imem_resp_valid) begin
                state_d = imem_resp_err ? S_FAULT : S_HOLD;
                instr_d = imem_resp_err ? instr_q : imem_resp_data;
            end
            // a misaligned next PC is still loaded so the faulting address is visible
            S_HOLD: if (commit) begin
                retire_d = retire_q + 64'd1;
                pc_d     = halt ? pc_q : npc;
                state_d  = halt ? S_HALTED : (|npc[1:0] ? S_FAULT : S_REQ);
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            retire_q <= 64'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
        end
    end
    assign imem_req_valid = state_q == S_REQ;
    assign imem_req_addr  = pc_q;
    assign pc             = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = state_q == S_HOLD;
    assign fetch_fault    = state_q == S_FAULT;
    assign halted         = state_q == S_HALTED;
    assign retire_cnt     = retire_q;
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000: PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request.
REQ-006 imem_req_addr  output  64  fetch address; equals pc.
REQ-007 imem_resp_valid  input  1  response data valid.
REQ-008 imem_resp_data  input  32  fetched instruction word.
REQ-009 imem_resp_err  input  1  access fault, qualified by imem_resp_valid.
REQ-010 instr  output  32  held instruction for decode.
REQ-011 instr_valid  output  1  instr and pc are valid for decode/execute.
REQ-012 pc  output  64  address of the current instruction.
REQ-013 commit  input  1  execute stage retires the held instruction this cycle.
REQ-014 npc_sel  input  2  next-PC select: 0 sequential, 1 branch-taken/jal, 2 jalr, 3 reserved.
REQ-015 branch_target  input  64  PC-relative target (branch/jal).
REQ-016 jalr_target  input  64  rs1+imm target (jalr).
REQ-017 halt  input  1  ebreak decoded; qualified by commit.
REQ-018 fetch_fault  output  1  sticky fault flag.
REQ-019 halted  output  1  sticky halt flag.
REQ-020 retire_cnt  output  64  count of committed instructions.

Function
REQ-021 The block SHALL implement states REQ, WAIT, HOLD, FAULT, HALTED.
REQ-022 REQ: imem_req_valid=1, imem_req_addr=pc; SHALL go to WAIT on the cycle imem_req_ready=1, else remain.
REQ-023 WAIT: imem_req_valid=0; on imem_resp_valid=1 with err=0 SHALL latch instr<=imem_resp_data and enter HOLD; with err=1 SHALL enter FAULT.
REQ-024 HOLD: instr_valid=1, instr and pc stable until commit.
REQ-025 HOLD with commit=1 and halt=0: pc SHALL update next edge to pc+4 (sel 0 or 3), branch_target (sel 1), or {jalr_target[63:1],1'b0} (sel 2); state goes to REQ.
REQ-026 HOLD with commit=1 and halt=1: pc SHALL NOT change; state goes to HALTED.
REQ-027 Next PC with bits[1:0]!=2'b00 SHALL enter FAULT instead of REQ, pc loaded with the offending value, no request issued.
REQ-028 retire_cnt SHALL increment by 1 on every HOLD cycle with commit=1 (including halt), wrapping from 2^64-1 to 0.
REQ-029 commit outside HOLD and imem_resp_valid outside WAIT SHALL be ignored.
REQ-030 instr_valid SHALL be 1 only in HOLD; it drops the cycle after commit.
REQ-031 FAULT: fetch_fault=1, no requests, instr_valid=0; exited only by reset. HALTED: halted=1, same restrictions.
REQ-032 pc+4 SHALL wrap modulo 2^64.
REQ-033 Minimum fetch latency: req accepted cycle N, resp cycle N+1, instr_valid=1 cycle N+2.

Reset
REQ-034 rst_n=0 SHALL immediately force state=REQ, pc=RESET_PC, instr=32'h0, instr_valid=0, fetch_fault=0, halted=0, retire_cnt=0.
REQ-035 imem_req_valid SHALL be 1 in the first cycle after rst_n rises.
REQ-036 Reset asserted mid-transaction (WAIT or HOLD) SHALL abort it; a later stale imem_resp_valid in REQ is ignored.

Verification
REQ-037 Reset release, ready=1, resp 1 cycle later data 32'h00000013 -> req addr 0x80000000, instr_valid=1 with instr=0x00000013, pc=0x80000000.
REQ-038 Commit with npc_sel=0 -> next req addr 0x80000004, retire_cnt=1.
REQ-039 Commit with npc_sel=2, jalr_target=0x80001003 -> pc=0x80001002, then FAULT (misaligned), fetch_fault=1, no further requests.
REQ-040 Commit with npc_sel=1, branch_target=0x80000100 -> req addr 0x80000100; ready held 0 for 3 cycles -> addr stable, state REQ.
REQ-041 Response with imem_resp_err=1 -> fetch_fault=1, instr_valid stays 0 until reset.
REQ-042 Commit with halt=1 at pc=0x80000008 -> halted=1, pc stays 0x80000008, retire_cnt incremented, no new requests; rst_n pulse low -> all outputs at reset values.
